calc_alu_sequencer: RTL and testbench
=====================================

// Module: calc_alu_sequencer
// PURPOSE
// - Multi-cycle arithmetic controller for the keypad calculator. The top-level FSM issues one operation
//   (plus/minus/multiply/divide) with a start/busy/done handshake.
// - Multiply runs as iterative shift-add and divide as restoring division, each over WIDTH cycles.
//   This replaces the single-cycle combinational multiplier and adds divide.
// - Results are range-checked against the 3-digit display limit before being handed back for display.
// PARAMETERS
// - WIDTH      10   operand/result width in bits
// - MAX_VALUE  999  largest displayable result; larger results saturate and set overflow
// PORTS
// - Clk          in   1      system clock (12 MHz)
// - reset        in   1      synchronous, active-high reset
// - start        in   1      request; sampled only when busy=0
// - op           in   2      0=PLUS 1=MINUS 2=MULTIPLY 3=DIVIDE; sampled with start
// - a            in   WIDTH  left operand (accumulated result); sampled with start
// - b            in   WIDTH  right operand (entered argument); sampled with start
// - busy         out  1      high while an operation is in flight
// - done         out  1      one-cycle pulse; result and flags are valid from this cycle
// - result       out  WIDTH  operation result, held until the next done
// - overflow     out  1      true result > MAX_VALUE; result forced to MAX_VALUE
// - negative     out  1      MINUS with b > a; result forced to 0
// - div_by_zero  out  1      DIVIDE with b == 0; result forced to 0
// BEHAVIOUR
// - Reset: state=IDLE; busy, done, result, overflow, negative and div_by_zero are all 0.
//   Reset mid-operation aborts the operation with no done pulse.
// - States:
//   - IDLE: start=1 latches op/a/b into internal registers, clears iteration counter -> ADDSUB | MUL | DIV.
//   - ADDSUB: one cycle, computes a+b or a-b -> FINISH.
//   - MUL: each cycle, if multiplier LSB is set, acc += multiplicand (acc is 2*WIDTH wide);
//     multiplicand <<= 1, multiplier >>= 1. After WIDTH iterations -> FINISH.
//   - DIV: if b==0 -> FINISH immediately. Otherwise WIDTH restoring steps, MSB first:
//     rem = {rem,dividend_msb}; if rem >= b then rem -= b and quotient bit = 1. Then -> FINISH.
//   - FINISH: applies range checks, registers result and flags, pulses done=1 -> IDLE.
// - Latency, counted from the start-sample edge to the edge that raises done:
//   - PLUS/MINUS: 2 edges.
//   - MULTIPLY/DIVIDE: WIDTH+2 edges (12 at default).
//   - DIVIDE by zero: 3 edges.
// - busy = (state != IDLE). busy is low in the done cycle, so a start in that same cycle is accepted.
// - start while busy=1 is ignored, not queued. a, b and op may change freely while busy.
// - Flags are mutually exclusive and valid only with done. They hold until the next done.
//   They are cleared by reset only.
// - Arithmetic: add uses a WIDTH+1 bit sum; multiply uses a 2*WIDTH bit product.
//   Overflow is tested on the full-width value, never on a truncated one.
// - Divide returns the quotient only (integer, truncated). The remainder is discarded.
// STRUCTURE
// - Shared include calc_defs.vh holds OP_PLUS/OP_MINUS/OP_MULTIPLY/OP_DIVIDE 2-bit codes and the
//   state encodings. The top-level calculator FSM uses the same op codes.
// - The natural sub-module is calc_div_step: a combinational restoring-division step
//   (rem_in, dividend bit, divisor -> rem_out, q_bit). Everything else lives in one clocked process.
// TESTING
// - reset, start op=PLUS a=123 b=456 -> done 2 edges later, result=579, all flags 0, busy high for 2 cycles.
// - op=MINUS a=5 b=7 -> result=0, negative=1. Then op=MINUS a=7 b=5 -> result=2, negative=0.
// - op=MULTIPLY a=31 b=32 -> done at edge 12, result=992, overflow=0.
//   Then a=32 b=32 -> result=999, overflow=1.
// - op=DIVIDE a=999 b=7 -> result=142 at edge 12. Then a=5 b=0 -> result=0, div_by_zero=1, done at edge 3.
// - start MULTIPLY a=20 b=20; pulse start with other operands at edges 3-5 -> ignored, result=400.
//   New start in the done cycle -> accepted.
// - start MULTIPLY, assert reset at edge 5 -> busy=0 and result=0 next cycle, no done pulse.
//   A following PLUS 1+1 returns 2.

Source files
------------

// File: rtl/calc_alu_sequencer_pkg.sv
// Shared op codes and sequencer state encoding for the calculator arithmetic path.
// The top-level calculator FSM issues operations using the same op_e codes.
package calc_alu_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_PLUS     = 2'd0,
        OP_MINUS    = 2'd1,
        OP_MULTIPLY = 2'd2,
        OP_DIVIDE   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDSUB = 3'd1,
        S_MUL    = 3'd2,
        S_DIV    = 3'd3,
        S_FINISH = 3'd4
    } state_e;

endpackage

// File: rtl/calc_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module calc_div_step #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial = {rem_in, dividend_bit};
    assign diff  = trial - {1'b0, divisor};
    assign q_bit = (trial >= {1'b0, divisor});
    // The restored remainder is always below the divisor, so WIDTH bits hold it.
    assign rem_out = WIDTH'(q_bit ? diff : trial);

endmodule

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle add/sub/multiply/divide sequencer with start/busy/done handshake
// and saturation of results to the display limit.
module calc_alu_sequencer
    import calc_alu_sequencer_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int MAX_VALUE = 999
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             negative,
    output logic             div_by_zero
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    fin_val;
    logic [CNT_W-1:0] cnt;

    function automatic logic exceeds_limit(input logic [PW-1:0] v);
        return v > PW'(MAX_VALUE);
    endfunction

    function automatic logic [WIDTH-1:0] saturate(input logic [PW-1:0] v);
        return exceeds_limit(v) ? WIDTH'(MAX_VALUE) : v[WIDTH-1:0];
    endfunction

    calc_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (rem),
        .dividend_bit (shreg[WIDTH-1]),
        .divisor      (b_q),
        .rem_out      (rem_next),
        .q_bit        (q_bit)
    );

    // shreg carries the multiplier (shifting right) or the dividend turning into the quotient.
    assign fin_val = (op_q == OP_DIVIDE) ? PW'(shreg) : acc;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            done        <= 1'b0;
            result      <= '0;
            overflow    <= 1'b0;
            negative    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op_e'(op);
                        a_q  <= a;
                        b_q  <= b;
                        cnt  <= '0;
                        case (op_e'(op))
                            OP_PLUS, OP_MINUS: state <= S_ADDSUB;
                            OP_MULTIPLY:       state <= S_MUL;
                            OP_DIVIDE:         state <= S_DIV;
                        endcase
                    end
                end
                S_ADDSUB: begin
                    acc   <= (op_q == OP_PLUS) ? PW'(a_q) + PW'(b_q) : PW'(a_q) - PW'(b_q);
                    state <= S_FINISH;
                end
                S_MUL: begin
                    // First cycle loads the shift-add datapath, then WIDTH iterations follow.
                    if (cnt == '0) begin
                        acc   <= '0;
                        mcand <= PW'(a_q);
                        shreg <= b_q;
                        cnt   <= CNT_W'(1);
                    end else begin
                        if (shreg[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand <= mcand << 1;
                        shreg <= shreg >> 1;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH)) begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_DIV: begin
                    if (cnt == '0) begin
                        rem   <= '0;
                        shreg <= a_q;
                        cnt   <= CNT_W'(1);
                    end else if (b_q == '0) begin
                        state <= S_FINISH;
                    end else begin
                        rem   <= rem_next;
                        shreg <= {shreg[WIDTH-2:0], q_bit};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH)) begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    overflow    <= 1'b0;
                    negative    <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (op_q == OP_DIVIDE && b_q == '0) begin
                        result      <= '0;
                        div_by_zero <= 1'b1;
                    end else if (op_q == OP_MINUS && b_q > a_q) begin
                        result   <= '0;
                        negative <= 1'b1;
                    end else begin
                        result   <= saturate(fin_val);
                        overflow <= exceeds_limit(fin_val);
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Directed and randomized checks of calc_alu_sequencer against an arithmetic reference model.
module tb_calc_alu_sequencer;

    localparam int W    = 10;
    localparam int MAXV = 999;

    logic         Clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         overflow;
    logic         negative;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    calc_alu_sequencer #(.WIDTH(W), .MAX_VALUE(MAXV)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .overflow    (overflow),
        .negative    (negative),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic followed by the display range rules.
    task automatic model(input int o, input int x, input int y,
                         output int res, output int ovf, output int neg, output int dz, output int lat);
        int v;
        v = 0; res = 0; ovf = 0; neg = 0; dz = 0; lat = 2;
        case (o)
            0: v = x + y;
            1: if (y > x) neg = 1; else v = x - y;
            2: begin v = x * y; lat = W + 2; end
            default: begin
                if (y == 0) begin dz = 1; lat = 3; end
                else begin v = x / y; lat = W + 2; end
            end
        endcase
        if (neg == 0 && dz == 0) begin
            if (v > MAXV) begin ovf = 1; res = MAXV; end
            else res = v;
        end
    endtask

    // mode 0: quiet inputs while busy; 1: random noise incl. start; 2: start pulses at edges 3-5.
    task automatic do_op(input string tag, input int o, input int x, input int y, input int mode);
        int er, eo, en, ed, el, edges;
        model(o, x, y, er, eo, en, ed, el);
        op = 2'(o); a = W'(x); b = W'(y); start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        check({tag, "/busy_on"}, {31'd0, busy}, 32'd1);
        check({tag, "/done_low"}, {31'd0, done}, 32'd0);
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (mode == 1) begin
                start = 1'($urandom_range(0, 1));
                op = 2'($urandom); a = W'($urandom); b = W'($urandom);
            end else if (mode == 2) begin
                start = (edges >= 2 && edges <= 4);
                op = 2'd0; a = W'(1); b = W'(1);
            end
            @(posedge Clk); #1;
            edges++;
        end
        start = 1'b0;
        check({tag, "/latency"}, edges, el);
        check({tag, "/result"}, {22'd0, result}, er);
        check({tag, "/overflow"}, {31'd0, overflow}, eo);
        check({tag, "/negative"}, {31'd0, negative}, en);
        check({tag, "/div_by_zero"}, {31'd0, div_by_zero}, ed);
        check({tag, "/busy_off"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        int o, x, y;

        reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("reset/busy", {31'd0, busy}, 32'd0);
        check("reset/done", {31'd0, done}, 32'd0);
        check("reset/result", {22'd0, result}, 32'd0);
        check("reset/flags", {29'd0, overflow, negative, div_by_zero}, 32'd0);
        reset = 1'b0;
        @(posedge Clk); #1;

        do_op("plus", 0, 123, 456, 0);
        do_op("minus_neg", 1, 5, 7, 1);
        do_op("minus", 1, 7, 5, 1);
        do_op("minus_eq", 1, 300, 300, 0);
        do_op("mul", 2, 31, 32, 1);
        do_op("mul_ovf", 2, 32, 32, 1);
        do_op("mul_max", 2, 1023, 1023, 0);
        do_op("plus_edge", 0, 500, 499, 0);
        do_op("plus_ovf", 0, 500, 500, 0);
        do_op("div", 3, 999, 7, 1);
        do_op("div_ovf", 3, 1023, 1, 0);
        do_op("div0", 3, 5, 0, 1);

        // Flags and result hold after the done pulse.
        repeat (3) @(posedge Clk);
        #1;
        check("hold/div_by_zero", {31'd0, div_by_zero}, 32'd1);
        check("hold/done", {31'd0, done}, 32'd0);

        do_op("mul_ignore", 2, 20, 20, 2);
        do_op("done_cycle_start", 0, 300, 700, 0);

        // Reset in the middle of a multiply aborts it without a done pulse.
        op = 2'd2; a = W'(100); b = W'(100); start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        reset = 1'b1;
        @(posedge Clk); #1;
        check("abort/busy", {31'd0, busy}, 32'd0);
        check("abort/result", {22'd0, result}, 32'd0);
        check("abort/overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge Clk); #1;
            if (done === 1'b1) seen++;
        end
        check("abort/no_done", seen, 0);
        do_op("after_reset", 0, 1, 1, 0);

        for (int i = 0; i < 24; i++) begin
            o = $urandom_range(0, 3);
            x = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1023) : $urandom_range(0, 40);
            y = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) y = $urandom_range(0, 40);
            do_op($sformatf("rand%0d", i), o, x, y, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
